// File: rtl/axil_rr_pkg.sv
// Shared types and constants for the round-robin AXI4-Lite master.
package axil_rr_pkg;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD      = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    // AXI response encodings
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Width of a requester index; a single requester still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant search from a registered pointer.
// The pointer moves to one past the served requester when i_advance pulses.
module rr_arbiter
    import axil_rr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    input  logic [IDX_W-1:0]   i_done_idx,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_found;

    // First requesting line at or above the pointer, wrapping past the top
    always_comb begin
        int j;
        j           = 0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!w_found && i_req[j]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(j);
            end
        end
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_grant[k] = w_found && (int'(w_grant_idx) == k);
        end
    end

    // Next pointer is (served + 1) mod NUM_REQ
    assign w_ptr_next = (int'(i_done_idx) >= NUM_REQ - 1) ? '0 : i_done_idx + 1'b1;

    // Pointer only moves when a transaction completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_grant_idx;
    assign o_any       = w_found;

endmodule

// File: rtl/axil_rr_master.sv
// Shares one AXI4-Lite master port among NUM_REQ local requesters.
// One transaction in flight at a time; completion is reported to the owner.
module axil_rr_master
    import axil_rr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [ADDR_W-1:0]             M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_W-1:0]             M_AXI_WDATA,
    output logic [DATA_W/8-1:0]           M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_W-1:0]             M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_W-1:0]             M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(NUM_REQ);

    state_t              r_state;
    logic [IDX_W-1:0]    r_gidx;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_arvalid;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_resp;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_complete;
    logic                w_aw_done;
    logic                w_w_done;
    logic [NUM_REQ-1:0]  w_done_onehot;

    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]   w_wstrb_arr [NUM_REQ];

    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [STRB_W-1:0]   w_sel_wstrb;

    // Split the packed request buses and decode the owner as one-hot
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_addr_arr[gi]    = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi]   = req_wdata[gi*DATA_W +: DATA_W];
        assign w_wstrb_arr[gi]   = req_wstrb[gi*STRB_W +: STRB_W];
        assign w_done_onehot[gi] = (r_gidx == IDX_W'(gi));
    end

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .i_req       (req_valid),
        .i_advance   (w_complete),
        .i_done_idx  (r_gidx),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // Requests are only looked at while idle; reset keeps req_ready low
    assign w_accept  = ARESETN && (r_state == ST_IDLE) && w_any;
    assign req_ready = w_accept ? w_grant : '0;

    // Select the granted requester's fields with the one-hot grant
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_we    = req_we[k];
                w_sel_addr  = w_addr_arr[k];
                w_sel_wdata = w_wdata_arr[k];
                w_sel_wstrb = w_wstrb_arr[k];
            end
        end
    end

    // A write channel is finished once its VALID has dropped or is handshaking now
    assign w_aw_done  = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done   = !r_wvalid  || M_AXI_WREADY;
    assign w_complete = ((r_state == ST_WR_RESP) && M_AXI_BVALID) ||
                        ((r_state == ST_RD_DATA) && M_AXI_RVALID);

    // Transaction sequencer, request latch and response register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_gidx      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= AXI_RESP_OKAY;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gidx  <= w_grant_idx;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wstrb <= w_sel_wstrb;
                        if (w_sel_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (r_awvalid && M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= w_done_onehot;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_valid <= w_done_onehot;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = (r_state == ST_WR_RESP);
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = (r_state == ST_RD_DATA);

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axil_rr_master.sv
// Scoreboard bench for axil_rr_master with a small AXI4-Lite slave model.
module tb_axil_rr_master;
    import axil_rr_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [DW-1:0]   M_AXI_WDATA, M_AXI_RDATA;
    logic [SW-1:0]   M_AXI_WSTRB;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;

    axil_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cycle = 0;
    always @(posedge ACLK) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] aw_exp[$];
    int          grant_log[$];
    int          acc_cycle[N];
    int          last_lat[N];
    int          awv_cnt = 0;
    int          wv_cnt  = 0;
    logic        bready_prev = 1'b0;
    logic        auto0 = 1'b0;
    int          aw_delay = 0;
    logic        ar_ready_en = 1'b1;
    logic [31:0] mem [16];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Raise a request and record what its completion must look like
    task automatic post(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] eresp, input logic [31:0] erdata);
        exp_t e;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = addr;
        req_wdata[i*DW +: DW]  = wdata;
        req_wstrb[i*SW +: SW]  = 4'hF;
        req_valid[i]           = 1'b1;
        e.owner = i;
        e.rdata = erdata;
        e.resp  = eresp;
        sb_q.push_back(e);
        if (we) aw_exp.push_back(addr);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((req_valid != '0 || sb_q.size() != 0) && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s pending=%0d required=0", name, sb_q.size());
            sb_q.delete();
            req_valid = '0;
        end
        tick(2);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        tick(2);
        ARESETN = 1'b1;
        tick(1);
    endtask

    // Requester side: drop req_valid after the accepting edge, log grants
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge ACLK);
            acc = req_ready & req_valid;
            if (req_ready != '0) begin
                chk("req_ready_onehot_subset", {63'd0, $onehot(req_ready) && ((req_ready & ~req_valid) == '0)}, 64'd1);
                for (int i = 0; i < N; i++) begin
                    if (acc[i]) begin
                        grant_log.push_back(i);
                        acc_cycle[i] = cycle;
                    end
                end
                @(posedge ACLK);
                #1;
                req_valid = req_valid & ~acc;
                if (auto0 && acc[0]) post(0, 1'b1, 32'h20, 32'hA5A5A5A5, AXI_RESP_OKAY, 32'h0);
            end
        end
    end

    // Response monitor: pop the owner's oldest expectation and compare
    initial begin
        int owner;
        int found;
        forever begin
            @(negedge ACLK);
            if (rsp_valid != '0) begin
                chk("rsp_valid_onehot", {63'd0, $onehot(rsp_valid)}, 64'd1);
                owner = 0;
                for (int i = N - 1; i >= 0; i--) if (rsp_valid[i]) owner = i;
                found = -1;
                for (int k = 0; k < sb_q.size(); k++) begin
                    if (found < 0 && sb_q[k].owner == owner) found = k;
                end
                checks++;
                if (found < 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp owner=%0d rsp_valid=0x%0h required=none", owner, rsp_valid);
                end else begin
                    $display("RSP owner=%0d rdata=0x%08h resp=%0d cycle=%0d", owner, rsp_rdata, rsp_resp, cycle);
                    chk($sformatf("rsp_rdata_r%0d", owner), {32'd0, rsp_rdata}, {32'd0, sb_q[found].rdata});
                    chk($sformatf("rsp_resp_r%0d", owner), {62'd0, rsp_resp}, {62'd0, sb_q[found].resp});
                    last_lat[owner] = cycle - acc_cycle[owner];
                    sb_q.delete(found);
                end
            end
            if (M_AXI_BREADY && !bready_prev)
                chk("bready_after_aw_w", {63'd0, M_AXI_AWVALID || M_AXI_WVALID}, 64'd0);
            bready_prev = M_AXI_BREADY;
            if (M_AXI_AWVALID) awv_cnt++;
            if (M_AXI_WVALID)  wv_cnt++;
        end
    end

    // AXI4-Lite slave model: optional AWREADY delay, SLVERR at 0x10
    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, awv;
        logic [31:0] aw_a, ar_a, wd, s_aw_addr, s_wdata;
        logic [3:0]  ws, s_wstrb;
        logic s_aw_got, s_w_got;
        int awcnt;
        for (int k = 0; k < 16; k++) mem[k] = 32'h0;
        s_aw_got = 1'b0; s_w_got = 1'b0; awcnt = 0;
        s_aw_addr = '0; s_wdata = '0; s_wstrb = '0;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs  = M_AXI_WVALID && M_AXI_WREADY;
            b_hs  = M_AXI_BVALID && M_AXI_BREADY;
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs  = M_AXI_RVALID && M_AXI_RREADY;
            awv   = M_AXI_AWVALID;
            aw_a  = M_AXI_AWADDR; ar_a = M_AXI_ARADDR;
            wd    = M_AXI_WDATA;  ws   = M_AXI_WSTRB;
            if (aw_hs) begin
                chk("awprot", {61'd0, M_AXI_AWPROT}, 64'd0);
                if (aw_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL aw_unexpected actual=0x%0h required=none", aw_a);
                end else begin
                    chk("aw_addr_order", {32'd0, aw_a}, {32'd0, aw_exp.pop_front()});
                end
            end
            if (ar_hs) chk("arprot", {61'd0, M_AXI_ARPROT}, 64'd0);
            @(posedge ACLK);
            #1;
            if (aw_hs) begin
                s_aw_addr = aw_a; s_aw_got = 1'b1; awcnt = 0;
                M_AXI_AWREADY = (aw_delay == 0);
            end else if (awv) begin
                awcnt++;
                M_AXI_AWREADY = (awcnt >= aw_delay);
            end else begin
                awcnt = 0;
                M_AXI_AWREADY = (aw_delay == 0);
            end
            if (w_hs) begin s_wdata = wd; s_wstrb = ws; s_w_got = 1'b1; end
            if (b_hs) M_AXI_BVALID = 1'b0;
            if (s_aw_got && s_w_got && !M_AXI_BVALID) begin
                if (s_aw_addr == 32'h10) begin
                    M_AXI_BRESP = AXI_RESP_SLVERR;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_aw_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    M_AXI_BRESP = AXI_RESP_OKAY;
                end
                M_AXI_BVALID = 1'b1;
                s_aw_got = 1'b0; s_w_got = 1'b0;
            end
            if (r_hs) M_AXI_RVALID = 1'b0;
            if (ar_hs) begin
                M_AXI_RDATA  = mem[ar_a[5:2]];
                M_AXI_RRESP  = AXI_RESP_OKAY;
                M_AXI_RVALID = 1'b1;
            end
            M_AXI_ARREADY = ar_ready_en;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        int n0;
        int pos;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        req_valid = 3'b001;
        #1;
        chk("rst_req_ready", {61'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {61'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        chk("rst_valids", {59'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 64'd0);
        req_valid = '0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        tick(2);

        // 1: write then read back, zero-wait slave
        post(0, 1'b1, 32'h4, 32'h2, AXI_RESP_OKAY, 32'h0);
        wait_drain("t1_wr");
        chk("t1_wr_latency", 64'(last_lat[0]), 64'd3);
        post(0, 1'b0, 32'h4, 32'h0, AXI_RESP_OKAY, 32'h2);
        wait_drain("t1_rd");

        // 2: simultaneous writes from a reset pointer, then readbacks
        do_reset();
        post(0, 1'b1, 32'h0, 32'h1, AXI_RESP_OKAY, 32'h0);
        post(1, 1'b1, 32'h4, 32'h2, AXI_RESP_OKAY, 32'h0);
        post(2, 1'b1, 32'h8, 32'h3, AXI_RESP_OKAY, 32'h0);
        wait_drain("t2_wr");
        post(0, 1'b0, 32'h0, 32'h0, AXI_RESP_OKAY, 32'h1);
        post(1, 1'b0, 32'h4, 32'h0, AXI_RESP_OKAY, 32'h2);
        post(2, 1'b0, 32'h8, 32'h0, AXI_RESP_OKAY, 32'h3);
        wait_drain("t2_rd");

        // 3: AWREADY delayed 3 cycles, WREADY immediate
        aw_delay = 3;
        tick(1);
        awv_cnt = 0; wv_cnt = 0;
        post(1, 1'b1, 32'h8, 32'hDEADBEEF, AXI_RESP_OKAY, 32'h0);
        wait_drain("t3_wr");
        chk("t3_awvalid_cycles", 64'(awv_cnt), 64'd4);
        chk("t3_wvalid_cycles", 64'(wv_cnt), 64'd1);
        aw_delay = 0;
        tick(1);
        post(1, 1'b0, 32'h8, 32'h0, AXI_RESP_OKAY, 32'hDEADBEEF);
        wait_drain("t3_rd");

        // 4: slave error passed through to the owner only
        post(2, 1'b1, 32'h10, 32'h55, AXI_RESP_SLVERR, 32'h0);
        wait_drain("t4_err");

        // 5: requester 0 streams writes, requester 1 issues one read
        auto0 = 1'b1;
        post(0, 1'b1, 32'h20, 32'hA5A5A5A5, AXI_RESP_OKAY, 32'h0);
        tick(5);
        n0 = grant_log.size();
        post(1, 1'b0, 32'h8, 32'h0, AXI_RESP_OKAY, 32'hDEADBEEF);
        tick(20);
        auto0 = 1'b0;
        wait_drain("t5");
        pos = -1;
        for (int k = n0; k < grant_log.size(); k++) if (pos < 0 && grant_log[k] == 1) pos = k;
        chk("t5_r1_grant_within_2", {63'd0, (pos >= 0) && (pos - n0 + 1 <= 2)}, 64'd1);

        // 6: reset while ARVALID is pending
        post(1, 1'b1, 32'h14, 32'h66, AXI_RESP_OKAY, 32'h0);
        wait_drain("t6_pre");
        ar_ready_en = 1'b0;
        tick(1);
        post(1, 1'b0, 32'h0, 32'h0, AXI_RESP_OKAY, 32'h1);
        tick(4);
        chk("t6_arvalid_before_rst", {63'd0, M_AXI_ARVALID}, 64'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("t6_arvalid_in_rst", {63'd0, M_AXI_ARVALID}, 64'd0);
        chk("t6_rready_in_rst", {63'd0, M_AXI_RREADY}, 64'd0);
        chk("t6_rsp_valid_in_rst", {61'd0, rsp_valid}, 64'd0);
        sb_q.delete();
        ar_ready_en = 1'b1;
        tick(2);
        ARESETN = 1'b1;
        tick(1);
        n0 = grant_log.size();
        post(2, 1'b0, 32'h0, 32'h0, AXI_RESP_OKAY, 32'h1);
        post(1, 1'b0, 32'h4, 32'h0, AXI_RESP_OKAY, 32'h2);
        wait_drain("t6_post");
        chk("t6_first_grant", 64'(grant_log.size() > n0 ? grant_log[n0] : 9), 64'd1);
        chk("t6_second_grant", 64'(grant_log.size() > n0 + 1 ? grant_log[n0 + 1] : 9), 64'd2);

        chk("aw_exp_drained", 64'(aw_exp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
